// File: rtl/vga_pkg.sv
// Shared VGA timing types, mode table and helpers.
// Used by vga_axis_counter and vga_timing_gen.
package vga_pkg;

    // One raster axis: active span, porches, sync width, sync level.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        logic        pol;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_mode_t;

    // 25.175 MHz, negative sync on both axes.
    localparam vga_mode_t VGA_640x480_60 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48, pol: 1'b0},
        v: '{active: 480, fp: 10, sync: 2, bp: 33, pol: 1'b0}
    };

    // 50 MHz.
    localparam vga_mode_t VGA_800x600_72 = '{
        h: '{active: 800, fp: 56, sync: 120, bp: 64, pol: 1'b1},
        v: '{active: 600, fp: 37, sync: 6, bp: 23, pol: 1'b1}
    };

    // 74.25 MHz.
    localparam vga_mode_t VGA_1280x720_60 = '{
        h: '{active: 1280, fp: 110, sync: 40, bp: 220, pol: 1'b1},
        v: '{active: 720, fp: 5, sync: 5, bp: 20, pol: 1'b1}
    };

    // Full period of one axis (pixels per line or lines per frame).
    function automatic int unsigned mode_total(input vga_axis_t axis);
        return axis.active + axis.fp + axis.sync + axis.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, registered sync, look-ahead active.
// Ports:
//   clk_pix  clock
//   rst_pix  synchronous active-high reset (parks at last position)
//   adv      advance the counter by one
//   cnt      current position 0..TOTAL-1 (registered)
//   sync     sync output at POL while in the sync window (registered)
//   act      next-state position is inside the active span (combinational)
//   wrap     current position is the last one of the axis
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned ACTIVE = 800,
    parameter int unsigned FP     = 40,
    parameter int unsigned SYNC   = 128,
    parameter int unsigned BP     = 88,
    parameter logic        POL    = 1'b1
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             adv,
    output logic [WIDTH-1:0] cnt,
    output logic             sync,
    output logic             act,
    output logic             wrap
);

    localparam vga_axis_t AX = '{
        active: ACTIVE, fp: FP, sync: SYNC, bp: BP, pol: POL
    };
    localparam int unsigned TOTAL = mode_total(AX);

    localparam logic [WIDTH-1:0] LAST     = WIDTH'(TOTAL - 1);
    localparam logic [WIDTH-1:0] ACT_END  = WIDTH'(ACTIVE);
    localparam logic [WIDTH-1:0] SYNC_BEG = WIDTH'(ACTIVE + FP);
    localparam logic [WIDTH-1:0] SYNC_END = WIDTH'(ACTIVE + FP + SYNC);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             sync_q;
    logic             sync_d;

    assign wrap = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (rst_pix) begin
            cnt_d = LAST;
        end else if (adv) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Decoding the next-state count lets sync land on the same edge
    // as the count it belongs to, straight out of a flop.
    always_comb begin
        sync_d = ~POL;
        if (cnt_d >= SYNC_BEG && cnt_d < SYNC_END) begin
            sync_d = POL;
        end
    end

    // Handed to the top so it can register the combined data enable.
    assign act = (cnt_d < ACT_END);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            cnt_q  <= LAST;
            sync_q <= ~POL;
        end else begin
            cnt_q  <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign cnt  = cnt_q;
    assign sync = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA raster timing generator, advancing on pix_stb.
// Ports:
//   clk_pix    clock
//   rst_pix    synchronous active-high reset
//   pix_stb    pixel advance enable (tie 1 when clk_pix is the pixel clock)
//   sx, sy     raster position
//   hsync      horizontal sync, level H_POL when active
//   vsync      vertical sync, level V_POL when active
//   de         data enable, inside the active area
//   line       high while sx==0
//   frame      high while sx==0 && sy==0
//   vbl        high while sx==0 && sy==V_ACTIVE
//   frame_cnt  completed-frame count (only with VGA_TIMING_FRAME_CNT_EN)
// All outputs are registered and change together on one clk_pix edge.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned CORDW    = 10,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter logic        H_POL    = 1'b1,
    parameter logic        V_POL    = 1'b1,
    parameter int unsigned FCNTW    = 16
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             pix_stb,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic             vbl
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [FCNTW-1:0] frame_cnt
`endif
);

    localparam vga_axis_t H_AX = '{
        active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP, pol: H_POL
    };
    localparam vga_axis_t V_AX = '{
        active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP, pol: V_POL
    };
    localparam int unsigned H_TOTAL = mode_total(H_AX);
    localparam int unsigned V_TOTAL = mode_total(V_AX);

    localparam logic [CORDW-1:0] VBL_PRE = CORDW'(V_ACTIVE - 1);

    if (H_ACTIVE == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: active, sync and back porch must be nonzero");
    end

    if (longint'(H_TOTAL) - 1 >= (longint'(1) << CORDW) ||
        longint'(V_TOTAL) - 1 >= (longint'(1) << CORDW)) begin : g_bad_cordw
        $error("vga_timing_gen: CORDW too narrow for H_TOTAL/V_TOTAL");
    end

    if (FCNTW == 0) begin : g_bad_fcntw
        $error("vga_timing_gen: FCNTW must be nonzero");
    end

    logic h_wrap;
    logic v_wrap;
    logic h_act;
    logic v_act;
    logic v_adv;

    // The vertical axis steps only on the strobe that ends a line.
    assign v_adv = pix_stb & h_wrap;

    vga_axis_counter #(
        .WIDTH  (CORDW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .adv     (pix_stb),
        .cnt     (sx),
        .sync    (hsync),
        .act     (h_act),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .WIDTH  (CORDW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .adv     (v_adv),
        .cnt     (sy),
        .sync    (vsync),
        .act     (v_act),
        .wrap    (v_wrap)
    );

    logic de_q;
    logic de_d;
    logic line_q;
    logic line_d;
    logic frame_q;
    logic frame_d;
    logic vbl_q;
    logic vbl_d;

    // Strobes track the position the raster is about to enter: it is
    // (0,*) exactly when a strobe hits the last pixel of a line.
    always_comb begin
        de_d    = h_act & v_act;
        line_d  = line_q;
        frame_d = frame_q;
        vbl_d   = vbl_q;
        if (rst_pix) begin
            de_d    = 1'b0;
            line_d  = 1'b0;
            frame_d = 1'b0;
            vbl_d   = 1'b0;
        end else if (pix_stb) begin
            line_d  = h_wrap;
            frame_d = h_wrap & v_wrap;
            vbl_d   = h_wrap & (sy == VBL_PRE);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            de_q    <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
            vbl_q   <= 1'b0;
        end else begin
            de_q    <= de_d;
            line_q  <= line_d;
            frame_q <= frame_d;
            vbl_q   <= vbl_d;
        end
    end

    assign de    = de_q;
    assign line  = line_q;
    assign frame = frame_q;
    assign vbl   = vbl_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FCNTW-1:0] fcnt_q;
    logic [FCNTW-1:0] fcnt_d;

    always_comb begin
        fcnt_d = fcnt_q;
        if (pix_stb & h_wrap & v_wrap) begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised self-checking bench for vga_timing_gen on a small raster.
// Expected values come from a position model advanced by the raster rules.
module tb_vga_timing_gen;

    localparam int CW = 5;
    localparam int HA = 20;
    localparam int HF = 3;
    localparam int HS = 4;
    localparam int HB = 5;
    localparam int VA = 12;
    localparam int VF = 2;
    localparam int VS = 3;
    localparam int VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam logic HP = 1'b1;
    localparam logic VP = 1'b0;
    localparam int FW = 2;
    localparam int VW = 2 * CW + 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stb = 1'b0;
    logic [CW-1:0] sx;
    logic [CW-1:0] sy;
    logic hsync;
    logic vsync;
    logic de;
    logic line;
    logic frame;
    logic vbl;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FW-1:0] frame_cnt;
`endif

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CORDW    (CW),
        .H_ACTIVE (HA),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .H_POL    (HP),
        .V_POL    (VP),
        .FCNTW    (FW)
    ) dut (
        .clk_pix (clk),
        .rst_pix (rst),
        .pix_stb (stb),
        .sx      (sx),
        .sy      (sy),
        .hsync   (hsync),
        .vsync   (vsync),
        .de      (de),
        .line    (line),
        .frame   (frame),
        .vbl     (vbl)
`ifdef VGA_TIMING_FRAME_CNT_EN
       ,.frame_cnt (frame_cnt)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference position and completed-frame count.
    int msx = HT - 1;
    int msy = VT - 1;
    int mfc = 0;

    logic [VW-1:0] act_vec;
    assign act_vec = {sx, sy, hsync, vsync, de, line, frame, vbl};

    function automatic logic [VW-1:0] exp_vec();
        logic hs;
        logic vs;
        logic e;
        logic ln;
        logic fr;
        logic vb;
        hs = (msx >= HA + HF && msx < HA + HF + HS) ? HP : ~HP;
        vs = (msy >= VA + VF && msy < VA + VF + VS) ? VP : ~VP;
        e  = (msx < HA) && (msy < VA);
        ln = (msx == 0);
        fr = (msx == 0) && (msy == 0);
        vb = (msx == 0) && (msy == VA);
        return {CW'(msx), CW'(msy), hs, vs, e, ln, fr, vb};
    endfunction

    // One clock: drive inputs, let the edge pass, step the model.
    task automatic tick(input logic r, input logic s);
        rst = r;
        stb = s;
        @(posedge clk);
        #1;
        if (r) begin
            msx = HT - 1;
            msy = VT - 1;
            mfc = 0;
        end else if (s) begin
            if (msx == HT - 1) begin
                msx = 0;
                msy = (msy == VT - 1) ? 0 : msy + 1;
            end else begin
                msx = msx + 1;
            end
            if (msx == 0 && msy == 0) mfc = mfc + 1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)));
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_vec: got %h want %h", act_vec, exp_vec());
            end
        end
        n_chk++;
        if ({sx, sy, de} !== {CW'(HT - 1), CW'(VT - 1), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_pos: got %0d,%0d de=%b want %0d,%0d de=0",
                     sx, sy, de, HT - 1, VT - 1);
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        n_chk++;
        if (frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_fcnt: got %0d want 0", frame_cnt);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_hold: got %h want %h", act_vec, exp_vec());
            end
        end
        tick(1'b0, 1'b1);
        n_chk++;
        if ({sx, sy, frame, line, de} !== {CW'(0), CW'(0), 3'b111}) begin
            n_fail++;
            $display("FAIL first_stb: got sx=%0d sy=%0d f=%b l=%b de=%b want 0 0 1 1 1",
                     sx, sy, frame, line, de);
        end
    endtask

    task automatic test_full_frames();
        int de_n = 0;
        int vbl_n = 0;
        int fr_n = 0;
        int fr_first = -1;
        int hs_n = 0;
        int vs_n = 0;
        for (int i = 1; i <= 2 * HT * VT; i++) begin
            tick(1'b0, 1'b1);
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_vec: got %h want %h", act_vec, exp_vec());
            end
            if (de) de_n++;
            if (vbl) begin
                vbl_n++;
                n_chk++;
                if (sy !== CW'(VA)) begin
                    n_fail++;
                    $display("FAIL vbl_row: got sy=%0d want %0d", sy, VA);
                end
            end
            if (frame) begin
                fr_n++;
                if (fr_first < 0) fr_first = i;
            end
            if (hsync == HP) hs_n++;
            if (vsync == VP) vs_n++;
        end
        n_chk++;
        if (de_n !== 2 * HA * VA) begin
            n_fail++;
            $display("FAIL de_count: got %0d want %0d", de_n, 2 * HA * VA);
        end
        n_chk++;
        if (vbl_n !== 2) begin
            n_fail++;
            $display("FAIL vbl_count: got %0d want 2", vbl_n);
        end
        n_chk++;
        if (fr_n !== 2 || fr_first !== HT * VT) begin
            n_fail++;
            $display("FAIL frame_period: got n=%0d first=%0d want n=2 first=%0d",
                     fr_n, fr_first, HT * VT);
        end
        n_chk++;
        if (hs_n !== 2 * VT * HS || vs_n !== 2 * VS * HT) begin
            n_fail++;
            $display("FAIL sync_width: got hs=%0d vs=%0d want hs=%0d vs=%0d",
                     hs_n, vs_n, 2 * VT * HS, 2 * VS * HT);
        end
    endtask

    task automatic test_random_stb();
        for (int i = 0; i < 1500; i++) begin
            tick(1'b0, 1'($urandom_range(0, 2) != 0));
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL rand_vec: got %h want %h", act_vec, exp_vec());
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            n_chk++;
            if (frame_cnt !== FW'(mfc)) begin
                n_fail++;
                $display("FAIL rand_fcnt: got %0d want %0d", frame_cnt, FW'(mfc));
            end
`endif
        end
    endtask

    task automatic test_half_rate();
        int fr_clk = 0;
        int ln_clk = 0;
        for (int k = 0; k < 2 * HT * VT; k++) begin
            tick(1'b0, 1'(k % 2 == 0));
            n_chk++;
            if (act_vec !== exp_vec()) begin
                n_fail++;
                $display("FAIL half_vec: got %h want %h", act_vec, exp_vec());
            end
            if (frame) fr_clk++;
            if (line) ln_clk++;
        end
        n_chk++;
        if (fr_clk !== 2 || ln_clk !== 2 * VT) begin
            n_fail++;
            $display("FAIL half_strobe: got frame=%0d line=%0d want 2 %0d",
                     fr_clk, ln_clk, 2 * VT);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(sx == CW'(13) && sy == CW'(7)) && guard < 2 * HT * VT) begin
            tick(1'b0, 1'b1);
            guard++;
        end
        n_chk++;
        if (guard >= 2 * HT * VT) begin
            n_fail++;
            $display("FAIL mid_reach: got sx=%0d sy=%0d want 13 7", sx, sy);
        end
        tick(1'b1, 1'b1);
        n_chk++;
        if ({sx, sy, de, hsync, vsync} !== {CW'(HT - 1), CW'(VT - 1), 1'b0, ~HP, ~VP}) begin
            n_fail++;
            $display("FAIL mid_reset: got sx=%0d sy=%0d de=%b want %0d %0d 0",
                     sx, sy, de, HT - 1, VT - 1);
        end
        n_chk++;
        if (act_vec !== exp_vec()) begin
            n_fail++;
            $display("FAIL mid_vec: got %h want %h", act_vec, exp_vec());
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        n_chk++;
        if (frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL mid_fcnt: got %0d want 0", frame_cnt);
        end
`endif
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        n_chk++;
        if ({sx, sy, frame} !== {CW'(0), CW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL mid_release: got sx=%0d sy=%0d f=%b want 0 0 1",
                     sx, sy, frame);
        end
    endtask

`ifdef VGA_TIMING_FRAME_CNT_EN
    task automatic test_frame_cnt();
        logic [FW-1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int idx = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 4 * HT * VT + 1; i++) begin
            tick(1'b0, 1'b1);
            if (frame && idx < 5) begin
                n_chk++;
                if (frame_cnt !== want[idx]) begin
                    n_fail++;
                    $display("FAIL fcnt_seq%0d: got %0d want %0d",
                             idx, frame_cnt, want[idx]);
                end
                idx++;
            end
        end
        n_chk++;
        if (idx !== 5) begin
            n_fail++;
            $display("FAIL fcnt_frames: got %0d want 5", idx);
        end
        tick(1'b1, 1'b1);
        n_chk++;
        if (frame_cnt !== '0) begin
            n_fail++;
            $display("FAIL fcnt_reset: got %0d want 0", frame_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_frames();
        test_random_stb();
        test_half_rate();
        test_reset_mid();
`ifdef VGA_TIMING_FRAME_CNT_EN
        test_frame_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
